// File: rtl/dac_spi_writer_if.sv
// Write-side handshake bundle for the DAC SPI writer: one word per valid/ready.
interface dac_spi_writer_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] wdat;
    logic                  wvalid;
    logic                  wready;

    modport master (output wdat, output wvalid, input wready);
    modport slave  (input wdat, input wvalid, output wready);
endinterface

// File: rtl/dac_spi_writer.sv
// Write-only SPI master (mode 0) for the VCO tuning DAC. It accepts one word
// into a single holding register, shifts frames out MSB first, and optionally
// strobes ldacn after each frame. All outputs come straight from flops.
module dac_spi_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int SCK_DIV    = 2,
    parameter int CS_SETUP   = 1,
    parameter int CS_HOLD    = 1,
    parameter int CS_GAP     = 2,
    parameter bit LDAC_EN    = 1'b1,
    parameter int LDAC_WIDTH = 2
) (
    input  logic             clk,
    input  logic             arstn,
    dac_spi_writer_if.slave  wr,
    output logic             sck,
    output logic             mosi,
    output logic             csn,
    output logic             ldacn,
    output logic             busy,
    output logic             frame_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(max2(SCK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP)), LDAC_WIDTH);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SCK_LAST   = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_LDAC, S_GAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [DATA_WIDTH-1:0]   hold_reg, hold_next;
    logic                    full_reg, full_next;
    logic                    sck_reg, sck_next;
    logic                    csn_reg, csn_next;
    logic                    ldacn_reg, ldacn_next;
    logic                    done_reg, done_next;
    logic                    wready_reg;
    logic                    busy_reg;
    logic                    pull;
    logic                    accept;

    // mosi is the top of the shift register; it is cleared when the frame ends
    assign mosi       = shift_reg[DATA_WIDTH-1];
    assign sck        = sck_reg;
    assign csn        = csn_reg;
    assign ldacn      = ldacn_reg;
    assign frame_done = done_reg;
    assign busy       = busy_reg;
    assign wr.wready  = wready_reg;

    // State, counters, datapath and output flops; reset aborts any frame at once
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            full_reg   <= 1'b0;
            sck_reg    <= 1'b0;
            csn_reg    <= 1'b1;
            ldacn_reg  <= 1'b1;
            done_reg   <= 1'b0;
            wready_reg <= 1'b1;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            hold_reg   <= hold_next;
            full_reg   <= full_next;
            sck_reg    <= sck_next;
            csn_reg    <= csn_next;
            ldacn_reg  <= ldacn_next;
            done_reg   <= done_next;
            wready_reg <= !full_next;
            busy_reg   <= (state_next != S_IDLE) || full_next;
        end
    end

    // Frame sequencer: phase timing, bit shifting and next values of the pins
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        sck_next   = sck_reg;
        csn_next   = csn_reg;
        ldacn_next = ldacn_reg;
        done_next  = 1'b0;
        pull       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (full_reg) begin
                    pull       = 1'b1;
                    shift_next = hold_reg;
                    csn_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = S_SHIFT;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_reg != SCK_LAST) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end else begin
                    cnt_next = '0;
                    if (!sck_reg) begin
                        sck_next = 1'b1;
                    end else begin
                        // falling edge: next bit appears together with the low phase
                        sck_next = 1'b0;
                        if (bit_reg == BIT_LAST) begin
                            state_next = S_HOLD;
                        end else begin
                            bit_next   = bit_reg + BIT_ONE;
                            shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    csn_next   = 1'b1;
                    shift_next = '0;
                    done_next  = 1'b1;
                    if (LDAC_EN) begin
                        ldacn_next = 1'b0;
                        state_next = S_LDAC;
                    end else begin
                        state_next = S_GAP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_LDAC: begin
                if (cnt_reg == LDAC_LAST) begin
                    cnt_next   = '0;
                    ldacn_next = 1'b1;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Holding register: a pull needs it full, an accept needs it empty, so they never collide
    always_comb begin
        accept    = wr.wvalid && !full_reg;
        full_next = full_reg;
        hold_next = hold_reg;
        if (pull) begin
            full_next = 1'b0;
        end
        if (accept) begin
            full_next = 1'b1;
            hold_next = wr.wdat;
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: two instances (default timing and a fast sweep
// without ldac), a queue-based scoreboard fed at each accepted handshake and a
// negedge monitor that decodes the SPI pins and checks each frame.
module tb_dac_spi_writer;

    localparam int NI    = 2;
    localparam int DW    = 16;
    localparam int SETUP = 1;
    localparam int HOLD  = 1;
    localparam int LW    = 2;
    localparam int SD_A  [NI] = '{2, 1};
    localparam int GAP_A [NI] = '{2, 1};
    localparam bit LDE_A [NI] = '{1'b1, 1'b0};

    typedef struct {
        logic [DW-1:0] d;
        longint        t;
    } item_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    longint cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [DW-1:0] wdat_a   [NI];
    logic          wvalid_a [NI];
    logic          wready_w [NI];
    logic          sck_w    [NI];
    logic          mosi_w   [NI];
    logic          csn_w    [NI];
    logic          ldacn_w  [NI];
    logic          busy_w   [NI];
    logic          fd_w     [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        dac_spi_writer_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.wdat     = wdat_a[gi];
        assign bus.wvalid   = wvalid_a[gi];
        assign wready_w[gi] = bus.wready;
        dac_spi_writer #(
            .DATA_WIDTH(DW), .SCK_DIV(SD_A[gi]), .CS_SETUP(SETUP), .CS_HOLD(HOLD),
            .CS_GAP(GAP_A[gi]), .LDAC_EN(LDE_A[gi]), .LDAC_WIDTH(LW)
        ) dut (
            .clk(clk), .arstn(arstn), .wr(bus),
            .sck(sck_w[gi]), .mosi(mosi_w[gi]), .csn(csn_w[gi]),
            .ldacn(ldacn_w[gi]), .busy(busy_w[gi]), .frame_done(fd_w[gi])
        );
    end

    // Reference timing derived from the frame description
    function automatic longint cs_low_len(input int i);
        return SETUP + 2 * SD_A[i] * DW + HOLD;
    endfunction
    function automatic longint period(input int i);
        return cs_low_len(i) + (LDE_A[i] ? LW : 0) + GAP_A[i] + 1;
    endfunction
    function automatic longint rise_at(input int i, input int k);
        return SETUP + SD_A[i] * (2 * k + 1);
    endfunction

    function automatic void chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endfunction

    // Scoreboard and monitor state
    item_t         exp_q [NI][$];
    item_t         cur      [NI];
    logic [DW-1:0] got_w    [NI];
    bit            in_frame [NI];
    bit            prev_csn [NI];
    bit            prev_sck [NI];
    bit            prev_mosi[NI];
    bit            prev_ldn [NI];
    int            low_cnt  [NI];
    int            nrise    [NI];
    int            tbad     [NI];
    int            mbad     [NI];
    int            ldac_cnt [NI];
    int            rise_tot [NI] = '{0, 0};
    longint        last_fall[NI];

    // Monitor: push accepted words, decode frames off the pins, compare at csn rise
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!arstn) begin
                exp_q[i].delete();
                in_frame[i]  = 1'b0;
                prev_csn[i]  = 1'b1;
                prev_sck[i]  = 1'b0;
                prev_mosi[i] = 1'b0;
                prev_ldn[i]  = 1'b1;
                last_fall[i] = -1000000;
            end else begin
                if (wvalid_a[i] && wready_w[i])
                    exp_q[i].push_back('{d: wdat_a[i], t: cyc + 1});
                if (prev_csn[i] && !csn_w[i]) begin
                    chk($sformatf("i%0d_frame_expected", i), exp_q[i].size() > 0, 1);
                    if (exp_q[i].size() > 0) begin
                        longint ef;
                        cur[i] = exp_q[i].pop_front();
                        ef = cur[i].t + 1;
                        if (last_fall[i] + period(i) > ef) ef = last_fall[i] + period(i);
                        chk($sformatf("i%0d_csn_fall_cycle", i), cyc, ef);
                    end else begin
                        cur[i] = '{d: '0, t: 0};
                    end
                    last_fall[i] = cyc;
                    in_frame[i]  = 1'b1;
                    low_cnt[i]   = 0;
                    nrise[i]     = 0;
                    tbad[i]      = 0;
                    mbad[i]      = 0;
                    got_w[i]     = '0;
                end
                if (!csn_w[i]) low_cnt[i]++;
                if (!prev_sck[i] && sck_w[i]) begin
                    rise_tot[i]++;
                    if (csn_w[i]) chk($sformatf("i%0d_sck_outside_cs", i), csn_w[i], 0);
                    if (cyc - last_fall[i] != rise_at(i, nrise[i])) tbad[i]++;
                    got_w[i] = {got_w[i][DW-2:0], mosi_w[i]};
                    nrise[i]++;
                end
                if (prev_sck[i] && sck_w[i] && (mosi_w[i] != prev_mosi[i])) mbad[i]++;
                if (!prev_csn[i] && csn_w[i] && in_frame[i]) begin
                    chk($sformatf("i%0d_data", i), got_w[i], cur[i].d);
                    chk($sformatf("i%0d_sck_rises", i), nrise[i], DW);
                    chk($sformatf("i%0d_csn_low_len", i), low_cnt[i], cs_low_len(i));
                    chk($sformatf("i%0d_frame_done", i), fd_w[i], 1);
                    chk($sformatf("i%0d_sck_timing_errs", i), tbad[i], 0);
                    chk($sformatf("i%0d_mosi_changes_hi", i), mbad[i], 0);
                    in_frame[i] = 1'b0;
                    ldac_cnt[i] = 0;
                end else if (fd_w[i]) begin
                    chk($sformatf("i%0d_frame_done_stray", i), fd_w[i], 0);
                end
                if (!ldacn_w[i]) begin
                    ldac_cnt[i]++;
                    if (!csn_w[i]) chk($sformatf("i%0d_ldacn_overlap", i), csn_w[i], 1);
                    if (!LDE_A[i]) chk($sformatf("i%0d_ldacn_disabled", i), ldacn_w[i], 1);
                end
                if (!prev_ldn[i] && ldacn_w[i])
                    chk($sformatf("i%0d_ldacn_width", i), ldac_cnt[i], LW);
                prev_csn[i]  = csn_w[i];
                prev_sck[i]  = sck_w[i];
                prev_mosi[i] = mosi_w[i];
                prev_ldn[i]  = ldacn_w[i];
            end
        end
    end

    task automatic check_rest(input int i, input string tag);
        chk({tag, "_csn"},        csn_w[i],    1);
        chk({tag, "_sck"},        sck_w[i],    0);
        chk({tag, "_mosi"},       mosi_w[i],   0);
        chk({tag, "_ldacn"},      ldacn_w[i],  1);
        chk({tag, "_wready"},     wready_w[i], 1);
        chk({tag, "_busy"},       busy_w[i],   0);
        chk({tag, "_frame_done"}, fd_w[i],     0);
    endtask

    // Present a word and hold wvalid until it is taken; wvalid stays high on return
    task automatic send(input int i, input logic [DW-1:0] d);
        int w;
        @(posedge clk); #1;
        wdat_a[i]   = d;
        wvalid_a[i] = 1'b1;
        w = 0;
        while (!wready_w[i] && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chk($sformatf("i%0d_send_wready", i), wready_w[i], 1);
        @(posedge clk); #1;
        chk($sformatf("i%0d_wready_full", i), wready_w[i], 0);
        chk($sformatf("i%0d_busy_full", i), busy_w[i], 1);
    endtask

    task automatic wait_idle(input int i);
        int w;
        w = 0;
        wvalid_a[i] = 1'b0;
        @(negedge clk);
        while ((in_frame[i] || exp_q[i].size() != 0 || busy_w[i] || !ldacn_w[i]) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("i%0d_idle_reached", i), busy_w[i], 0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            wdat_a[i]   = '0;
            wvalid_a[i] = 1'b0;
        end
        #23;
        check_rest(0, "reset0");
        check_rest(1, "reset1");
        @(negedge clk);
        arstn = 1'b1;

        // idle for 100 cycles: nothing moves
        begin
            int r0;
            r0 = rise_tot[0];
            repeat (100) @(negedge clk);
            check_rest(0, "idle100");
            chk("idle100_sck_rises", rise_tot[0] - r0, 0);
        end

        // single known word
        send(0, 16'hA5C3);
        $display("[TB] inst0 single word 0xa5c3 sent");
        wait_idle(0);

        // back-to-back stream with wvalid held high
        send(0, 16'h0000);
        send(0, 16'hFFFF);
        send(0, 16'h8001);
        send(0, 16'h1234);
        $display("[TB] inst0 stream of 4 words sent");
        wait_idle(0);

        // fast instance: single word then a streamed pair
        send(1, 16'h0F0F);
        $display("[TB] inst1 word 0x0f0f sent");
        wait_idle(1);
        send(1, 16'h3C5A);
        send(1, 16'hC3A5);
        $display("[TB] inst1 stream of 2 words sent");
        wait_idle(1);

        // reset at the 8th sck rise with one word pending
        send(0, 16'h5A5A);
        send(0, 16'h6B6B);
        wvalid_a[0] = 1'b0;
        begin
            int n, w;
            bit ps;
            n = 0; w = 0; ps = sck_w[0];
            while (n < 8 && w < 2000) begin
                @(posedge clk); #1;
                if (sck_w[0] && !ps) n++;
                ps = sck_w[0];
                w++;
            end
            chk("rst_found_8th_rise", n, 8);
            arstn = 1'b0;
            #1;
            check_rest(0, "rst_mid");
            repeat (3) @(negedge clk);
            arstn = 1'b1;
            n = rise_tot[0];
            repeat (200) @(negedge clk);
            chk("rst_no_restart_rises", rise_tot[0] - n, 0);
            check_rest(0, "rst_after");
            $display("[TB] inst0 reset mid-frame done");
        end
        send(0, 16'h1357);
        wait_idle(0);

        // word arriving while the pull edge happens: goes out next, once
        send(0, 16'hBEEF);
        send(0, 16'hCAFE);
        $display("[TB] inst0 pull-edge pair sent");
        wait_idle(0);

        // randomized traffic on both instances
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 10; n++) begin
                logic [DW-1:0] d;
                d = DW'($urandom_range(0, 65535));
                send(i, d);
                $display("[TB] inst%0d random word 0x%04h sent", i, d);
                if ($urandom_range(0, 2) == 0) begin
                    wvalid_a[i] = 1'b0;
                    repeat ($urandom_range(0, 80)) @(posedge clk);
                end
            end
            wait_idle(i);
        end

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dac_spi_writer.md
# dac_spi_writer

Write-only SPI master that serialises DAC code words into DAC frames for the VCO tuning DAC. It sits directly downstream of the VCO sweep controller. It accepts one word per valid/ready handshake and buffers one pending word so sweep steps can stream back-to-back. It generates csn/sck/mosi plus an optional ldacn latch pulse, and reports frame completion.

## Interface
- DATA_WIDTH, 16, bits per frame, sent MSB first.
- SCK_DIV, 2, sck half-period in clk cycles; must be ≥1.
- CS_SETUP, 1, clk cycles from csn fall to first sck rise edge window; must be ≥1.
- CS_HOLD, 1, clk cycles csn stays low after last sck high phase; must be ≥1.
- CS_GAP, 2, minimum clk cycles csn stays high between frames; must be ≥1.
- LDAC_EN, 1, 1 = emit ldacn pulse after each frame.
- LDAC_WIDTH, 2, ldacn low width in clk cycles; must be ≥1.
- clk  in  1  system clock.
- arstn  in  1  asynchronous active-low reset.
- wdat  in  DATA_WIDTH  word to transmit.
- wvalid  in  1  wdat valid.
- wready  out  1  holding register empty; a word is accepted when wvalid&&wready at a clk edge.
- sck  out  1  SPI clock, idle low (mode 0).
- mosi  out  1  SPI data, stable across each sck rising edge.
- csn  out  1  chip select, active low.
- ldacn  out  1  DAC latch strobe, active low.
- busy  out  1  high whenever FSM is not IDLE or holding register is full.
- frame_done  out  1  one-cycle pulse on the cycle csn returns high.

## Operation
- Reset (arstn low, asynchronous): sck=0, mosi=0, csn=1, ldacn=1, wready=1, busy=0, frame_done=0; FSM=IDLE; holding register empty; any pending or in-flight word discarded. Reset mid-frame aborts immediately with csn high. No partial frame resumes after reset.
- Holding register: loads wdat on accept and clears wready. It empties (wready=1) on the edge where the FSM leaves IDLE with it. The accepting edge and the pull edge may coincide with a new accept only if the register is empty. wready is registered, so there is no combinational path from wvalid.
- FSM states: IDLE, SETUP, SHIFT, HOLD, LDAC, GAP.
- IDLE: if holding full, copy the word into the shift register, drive csn=0 and mosi=MSB, and go to SETUP.
- SETUP: lasts CS_SETUP cycles with sck=0, then goes to SHIFT.
- SHIFT: each bit is SCK_DIV cycles sck=0 followed by SCK_DIV cycles sck=1. mosi changes only at the start of a low phase, never while sck=1. The bit counter counts DATA_WIDTH bits. After the last high phase, sck=0 and the FSM goes to HOLD.
- HOLD: lasts CS_HOLD cycles with csn=0. Then csn=1 and mosi=0, and frame_done pulses for 1 cycle. Next state is LDAC if LDAC_EN, else GAP.
- LDAC: ldacn=0 for LDAC_WIDTH cycles, then GAP.
- GAP: csn=1 for CS_GAP cycles, then IDLE.
- Words arriving during a frame wait in the holding register. A third word stalls via wready=0 and is never dropped or overwritten.
- No word is ever reordered or duplicated.
- Counters are sized to hold the maximum of the parameter values. Bit count is clog2(DATA_WIDTH+1) bits.

## Timing
- Accept at edge N: holding register full after N. csn falls at edge N+1 if IDLE; otherwise it falls 1 cycle after the FSM returns to IDLE.
- csn low duration = CS_SETUP + 2·SCK_DIV·DATA_WIDTH + CS_HOLD cycles. With defaults this is 1+64+1 = 66.
- With defaults, LDAC_EN=1, and continuous streaming, the csn-fall-to-csn-fall period = 66 + LDAC_WIDTH + CS_GAP + 1 (IDLE) = 71 cycles.
- Relative to the csn fall edge, the first sck rise occurs at CS_SETUP+SCK_DIV cycles. For bit k (k=0 is the MSB), the sck rise is at CS_SETUP + SCK_DIV·(2k+1).
- ldacn falls on the same edge at which csn rises (plus frame_done). It never overlaps csn low.
- All outputs are registered and glitch-free.

## Test plan
- Reset then idle, wvalid=0 for 100 cycles: outputs hold their reset values, busy=0, and there are no sck edges.
- Single word 16'hA5C3: csn is low for exactly 66 cycles. Sampling mosi on sck rises gives 1010_0101_1100_0011, and there are exactly 16 sck rises. frame_done fires once, then ldacn is low for 2 cycles.
- Stream 4 words (0x0000, 0xFFFF, 0x8001, 0x1234) with wvalid held high: wready deasserts while the buffer is full. All 4 frames are received in order, with a 71-cycle csn period and no gaps beyond that.
- Parameter sweep SCK_DIV=1, LDAC_EN=0, CS_GAP=1 with word 0x0F0F: csn is low for 34 cycles, ldacn stays 1, and the period is 36 cycles.
- Assert arstn low at the 8th sck rise of a frame with one word pending: csn/sck/mosi return to 1/0/0 immediately. After release, no frame starts until a new word is accepted.
- wvalid pulses that coincide with the IDLE→SETUP pull edge: the new word is accepted into the emptied holding register and transmitted next, with no loss or duplication.
